// File: rtl/dphy_tx_lane_framer.sv
// D-PHY HS lane framer: prepare zeros, 0xB8 sync, payload, polarity-opposite trailer, LP exit gap.
// Accepted byte appears on hs_byte_o one cycle later; ready is held only while streaming, and a dropped valid ends the burst.
module dphy_tx_lane_framer #(
    parameter int unsigned PREP_CYCLES  = 4,
    parameter int unsigned TRAIL_CYCLES = 4,
    parameter int unsigned EXIT_CYCLES  = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [7:0] pkt_data_i,
    input  logic       pkt_valid_i,
    input  logic       pkt_last_i,
    output logic       pkt_ready_o,
    output logic       hs_en_o,
    output logic [7:0] hs_byte_o,
    output logic       busy_o,
    output logic       underflow_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PREP  = 3'd1;
    localparam logic [2:0] S_SYNC  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_TRAIL = 3'd4;
    localparam logic [2:0] S_EXIT  = 3'd5;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;
    localparam logic [7:0] PREP_LD   = 8'(PREP_CYCLES);
    localparam logic [7:0] TRAIL_LD  = 8'(TRAIL_CYCLES);
    localparam logic [7:0] EXIT_LD   = 8'(EXIT_CYCLES);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] byte_q, byte_d;
    logic       done_q, done_d;
    logic       uf_q, uf_d;
    logic [7:0] trail_byte;

    // done_q marks the cycle that shows the last payload byte; ready is already low there
    assign pkt_ready_o = (state_q == S_SYNC) || ((state_q == S_DATA) && !done_q);
    assign trail_byte  = byte_q[7] ? 8'h00 : 8'hFF;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        done_d  = done_q;
        uf_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                byte_d = 8'h00;
                done_d = 1'b0;
                if (pkt_valid_i) begin
                    state_d = S_PREP;
                    cnt_d   = PREP_LD;
                end
            end
            S_PREP: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_SYNC;
                    cnt_d   = 8'd0;
                    byte_d  = SYNC_BYTE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SYNC, S_DATA: begin
                if (done_q || !pkt_valid_i) begin
                    // normal end or starvation both close the burst off the byte now on the lane
                    state_d = S_TRAIL;
                    cnt_d   = TRAIL_LD;
                    byte_d  = trail_byte;
                    done_d  = 1'b0;
                    uf_d    = !done_q;
                end else begin
                    state_d = S_DATA;
                    byte_d  = pkt_data_i;
                    done_d  = pkt_last_i;
                end
            end
            S_TRAIL: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_EXIT;
                    cnt_d   = EXIT_LD;
                    byte_d  = 8'h00;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_EXIT: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                byte_d  = 8'h00;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            byte_q  <= 8'h00;
            done_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            done_q  <= done_d;
            uf_q    <= uf_d;
        end
    end

    assign hs_en_o     = (state_q == S_PREP) || (state_q == S_SYNC) ||
                         (state_q == S_DATA) || (state_q == S_TRAIL);
    assign hs_byte_o   = byte_q;
    assign busy_o      = (state_q != S_IDLE);
    assign underflow_o = uf_q;

endmodule

// File: tb/tb_dphy_tx_lane_framer.sv
// Bench for dphy_tx_lane_framer: two instances (default and minimal timing) checked per cycle against a burst-trace model.
module tb_dphy_tx_lane_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       vld;
    logic [7:0] dat;
    logic       last;
    logic       sel;

    logic       a_rdy, a_en, a_busy, a_uf;
    logic [7:0] a_byte;
    logic       b_rdy, b_en, b_busy, b_uf;
    logic [7:0] b_byte;

    dphy_tx_lane_framer u_dut_a (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pkt_data_i  (dat),
        .pkt_valid_i (vld & ~sel),
        .pkt_last_i  (last),
        .pkt_ready_o (a_rdy),
        .hs_en_o     (a_en),
        .hs_byte_o   (a_byte),
        .busy_o      (a_busy),
        .underflow_o (a_uf)
    );

    dphy_tx_lane_framer #(
        .PREP_CYCLES  (1),
        .TRAIL_CYCLES (1),
        .EXIT_CYCLES  (1)
    ) u_dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pkt_data_i  (dat),
        .pkt_valid_i (vld & sel),
        .pkt_last_i  (last),
        .pkt_ready_o (b_rdy),
        .hs_en_o     (b_en),
        .hs_byte_o   (b_byte),
        .busy_o      (b_busy),
        .underflow_o (b_uf)
    );

    logic       o_rdy, o_en, o_busy, o_uf;
    logic [7:0] o_byte;
    assign o_rdy  = sel ? b_rdy  : a_rdy;
    assign o_en   = sel ? b_en   : a_en;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_uf   = sel ? b_uf   : a_uf;
    assign o_byte = sel ? b_byte : a_byte;

    typedef struct packed {
        logic       en;
        logic [7:0] byt;
        logic       rdy;
        logic       uf;
        logic       busy;
        logic       vld;
        logic [7:0] dat;
        logic       last;
    } step_t;

    step_t      tr[$];
    logic [7:0] pkt[$];
    int         pm, tm, em;
    int         checks = 0;
    int         passed = 0;
    int         fails  = 0;

    task automatic check(input string tag, input int cyc, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s cyc %0d: observed %02h expected %02h", tag, cyc, obs, exp);
        end
    endtask

    function automatic step_t st(input logic en, input logic [7:0] b, input logic rdy,
                                 input logic uf, input logic busy);
        step_t s;
        s.en   = en;
        s.byt  = b;
        s.rdy  = rdy;
        s.uf   = uf;
        s.busy = busy;
        s.vld  = 1'($urandom);
        s.dat  = 8'($urandom);
        s.last = 1'($urandom);
        return s;
    endfunction

    // Expected lane trace of one burst; valid drops after m accepted bytes (m == size means no drop).
    task automatic build(input int m);
        step_t      s;
        logic [7:0] prev;
        logic [7:0] tb_byte;
        logic       drop;
        int         n;
        n = pkt.size();
        prev = 8'h00;
        drop = 1'b0;
        tr.delete();
        s = st(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        s.vld = 1'b1;
        tr.push_back(s);
        for (int i = 1; i <= pm; i++) tr.push_back(st(1'b1, 8'h00, 1'b0, 1'b0, 1'b1));
        for (int j = 0; j <= n; j++) begin
            if (j == 0) tb_byte = 8'hB8;
            else        tb_byte = pkt[j-1];
            s = st(1'b1, tb_byte, 1'b1, 1'b0, 1'b1);
            if (j < m) begin
                s.vld  = 1'b1;
                s.dat  = pkt[j];
                s.last = (j == n - 1);
                tr.push_back(s);
                if (j == n - 1) begin
                    tr.push_back(st(1'b1, pkt[j], 1'b0, 1'b0, 1'b1));
                    prev = pkt[j];
                    break;
                end
            end else begin
                s.vld = 1'b0;
                tr.push_back(s);
                prev = tb_byte;
                drop = 1'b1;
                break;
            end
        end
        for (int t = 0; t < tm; t++)
            tr.push_back(st(1'b1, prev[7] ? 8'h00 : 8'hFF, 1'b0, drop && (t == 0), 1'b1));
        for (int e = 0; e < em; e++) tr.push_back(st(1'b0, 8'h00, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic step_check(input string tag, input int c, input step_t s);
        check({tag, ".en"},   c, {7'd0, o_en},   {7'd0, s.en});
        check({tag, ".byte"}, c, o_byte,         s.byt);
        check({tag, ".rdy"},  c, {7'd0, o_rdy},  {7'd0, s.rdy});
        check({tag, ".uf"},   c, {7'd0, o_uf},   {7'd0, s.uf});
        check({tag, ".busy"}, c, {7'd0, o_busy}, {7'd0, s.busy});
    endtask

    task automatic run(input string tag, input int upto);
        for (int c = 0; c < upto && c < tr.size(); c++) begin
            vld  = tr[c].vld;
            dat  = tr[c].dat;
            last = tr[c].last;
            #1;
            step_check(tag, c, tr[c]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input string tag, input int k);
        for (int c = 0; c < k; c++) begin
            vld  = 1'b0;
            dat  = 8'($urandom);
            last = 1'($urandom);
            #1;
            step_check(tag, c, st(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_bursts(input string tag, input int count);
        int n, m;
        for (int r = 0; r < count; r++) begin
            n = $urandom_range(1, 6);
            pkt.delete();
            for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) m = $urandom_range(0, n - 1);
            else                           m = n;
            build(m);
            run(tag, tr.size());
            idle({tag, ".gap"}, $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = 1'b0;
        dat   = 8'h00;
        last  = 1'b0;
        sel   = 1'b0;
        pm = 4; tm = 4; em = 8;
        #2;
        step_check("rst_a", 0, st(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        sel = 1'b1;
        #1;
        step_check("rst_b", 0, st(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        sel = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle("idle0", 2);

        pkt = '{8'h11, 8'h22, 8'h33};
        build(3);
        run("basic", tr.size());
        idle("post_basic", 2);

        pkt = '{8'h12, 8'h80};
        build(2);
        run("end80", tr.size());
        pkt = '{8'h7F};
        build(1);
        run("end7f", tr.size());
        idle("post_pol", 1);

        // back-to-back: second burst's IDLE cycle directly follows the last EXIT cycle
        pkt = '{8'h01, 8'h02};
        build(2);
        run("b2b_1", tr.size());
        pkt = '{8'h03, 8'h04, 8'h05};
        build(3);
        run("b2b_2", tr.size());

        pkt = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h99};
        build(2);
        run("uflow", tr.size());
        pkt = '{8'hC3, 8'h3C, 8'h99};
        build(3);
        run("uflow_rest", tr.size());

        pkt = '{8'hE1};
        build(0);
        run("uflow_sync", tr.size());
        idle("post_uf", 1);

        pkt = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        build(5);
        run("pre_rst", pm + 3);
        vld = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        step_check("rst_mid", 0, st(1'b0, 8'h00, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        vld = 1'b0;
        @(posedge clk);
        #1;
        idle("post_rst", 2);
        pkt = '{8'h9C, 8'h6D};
        build(2);
        run("after_rst", tr.size());

        random_bursts("rnd_a", 15);

        sel = 1'b1;
        pm = 1; tm = 1; em = 1;
        idle("idle_b", 1);
        pkt = '{8'hC3};
        build(1);
        run("min_c3", tr.size());
        idle("post_min", 1);
        random_bursts("rnd_b", 15);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/dphy_tx_lane_framer.md
DPHY_TX_LANE_FRAMER -- requirements
Module: dphy_tx_lane_framer

Interface
REQ-001 Parameter: PREP_CYCLES, default 4, number of HS-prepare/zero cycles before sync byte (legal 1..255).
REQ-002 Parameter: TRAIL_CYCLES, default 4, number of HS-trailer byte cycles after last data byte (legal 1..255).
REQ-003 Parameter: EXIT_CYCLES, default 8, number of LP gap cycles after trailer before next burst may start (legal 1..255).
REQ-004 Port: clk_i  input  1  byte clock; all logic on rising edge.
REQ-005 Port: rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 Port: pkt_data_i  input  8  packet byte, bit 0 transmitted first on the lane.
REQ-007 Port: pkt_valid_i  input  1  pkt_data_i valid.
REQ-008 Port: pkt_last_i  input  1  current byte is last byte of packet.
REQ-009 Port: pkt_ready_o  output  1  framer accepts byte this cycle (transfer = valid & ready).
REQ-010 Port: hs_en_o  output  1  lane in HS mode (prepare, sync, data, trailer).
REQ-011 Port: hs_byte_o  output  8  byte to serializer, registered.
REQ-012 Port: busy_o  output  1  state != IDLE.
REQ-013 Port: underflow_o  output  1  one-cycle pulse: pkt_valid_i dropped mid-packet.

Function
REQ-014 States SHALL be IDLE, PREPARE, SYNC, DATA, TRAILER, EXIT; 8-bit down-counter for PREPARE/TRAILER/EXIT.
REQ-015 Cycle numbering: cycle 0 = first IDLE cycle with pkt_valid_i=1; P=PREP_CYCLES, T=TRAIL_CYCLES, E=EXIT_CYCLES.
REQ-016 IDLE: hs_en_o=0, hs_byte_o=0x00, pkt_ready_o=0; pkt_valid_i=1 moves to PREPARE; no byte consumed in IDLE.
REQ-017 PREPARE, cycles 1..P: hs_en_o=1, hs_byte_o=0x00, pkt_ready_o=0.
REQ-018 SYNC, cycle P+1: hs_en_o=1, hs_byte_o=0xB8 (sync pattern 8'b10111000), pkt_ready_o=1.
REQ-019 DATA: pkt_ready_o=1 (combinational from state) in cycle P+1 and every following cycle until last byte accepted.
REQ-020 Byte accepted in cycle k SHALL appear on hs_byte_o in cycle k+1 (latency 1), bytes in order, none dropped or duplicated.
REQ-021 Transfer with pkt_last_i=1 in cycle L: pkt_ready_o=0 from cycle L+1; TRAILER occupies cycles L+2..L+1+T.
REQ-022 Trailer byte SHALL be 0x00 if bit 7 of last transmitted hs_byte_o is 1, else 0xFF; constant for all T cycles; hs_en_o=1.
REQ-023 EXIT: hs_en_o=0, hs_byte_o=0x00, pkt_ready_o=0 for E cycles; then IDLE; earliest next cycle 0 is first IDLE cycle.
REQ-024 Underflow: pkt_valid_i=0 in a cycle k with pkt_ready_o=1 SHALL end burst: TRAILER starts cycle k+1, underflow_o=1 in cycle k+1 only, pkt_ready_o=0 from k+1.
REQ-025 Underflow trailer polarity per REQ-022 using byte output in cycle k (0xB8 if k=P+1, giving trailer 0x00).
REQ-026 pkt_valid_i/pkt_data_i/pkt_last_i SHALL be ignored when pkt_ready_o=0.
REQ-027 pkt_last_i on the first accepted byte SHALL yield a one-byte payload (legal).
REQ-028 busy_o=1 in all states except IDLE; hs_en_o never toggles within a burst.

Reset
REQ-029 rst_n_i low SHALL asynchronously force IDLE, counters 0, hs_en_o=0, hs_byte_o=0x00, pkt_ready_o=0, busy_o=0, underflow_o=0.
REQ-030 Reset mid-burst SHALL abort without trailer; after release, first cycle is IDLE, no residual byte emitted.
REQ-031 Release of rst_n_i SHALL be synchronised externally; first active edge after release evaluates IDLE.

Verification
REQ-032 Defaults, packet 0x11,0x22,0x33(last), valid held -> hs_en_o high cycles 1..12; bytes 00,00,00,00,B8,11,22,33,FF,FF,FF,FF; then 8 cycles LP 0x00.
REQ-033 Packet ending 0x80 (last) -> trailer 0x00 x4; packet ending 0x7F -> trailer 0xFF x4.
REQ-034 Two packets back-to-back valid -> second burst prepare starts exactly after 8 EXIT cycles; pkt_ready_o=0 throughout EXIT.
REQ-035 pkt_valid_i dropped after 2 of 5 bytes (0xA5,0x5A) -> underflow_o single pulse aligned with first trailer byte 0xFF; remaining bytes not accepted until next burst.
REQ-036 rst_n_i pulsed low during DATA -> outputs 0 immediately (before next edge), next burst after release starts with full PREP_CYCLES zeros then 0xB8.
REQ-037 PREP_CYCLES=1, TRAIL_CYCLES=1, EXIT_CYCLES=1, single byte 0xC3 -> bytes 00,B8,C3,00 with hs_en_o high 4 cycles, 1 LP cycle, then IDLE.
